// File: rtl/fifo_axis_sequencer.sv
// fifo_axis_sequencer: drains a show-ahead FIFO into an AXI4-Stream video frame of
// LINE_LEN x LINES beats. tlast marks the last beat of each line, and tuser marks
// the first beat of the frame. Each start pulse seen in IDLE arms exactly one frame.
// Optional feature: define SEQ_STALL_CNT_EN to add the 16-bit stall_cnt output,
// which counts the cycles spent starved by an empty FIFO.
module fifo_axis_sequencer #(
    parameter int WIDTH    = 8,
    parameter int LINE_LEN = 640,
    parameter int LINES    = 480
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             start,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_read_data,
    output logic             fifo_read_en,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    output logic             busy,
`ifdef SEQ_STALL_CNT_EN
    output logic [15:0]      stall_cnt,
`endif
    output logic             frame_done
);

    localparam int CW = 12;
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_LEN - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(LINES - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    col_q, col_d, row_q, row_d;
    logic [WIDTH-1:0] tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;
    logic             tuser_q, tuser_d;
    logic             done_q, done_d;

    logic pop, hs, frame_end_pop;

    // Pop only when streaming and the output register is free or draining this cycle.
    assign hs            = tvalid_q & m_axis_tready;
    assign pop           = (state_q == S_STREAM) & ~fifo_empty & (~tvalid_q | m_axis_tready);
    assign frame_end_pop = pop & (col_q == COL_LAST) & (row_q == ROW_LAST);

    assign fifo_read_en  = pop;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign busy          = (state_q != S_IDLE);
    assign frame_done    = done_q;

    // Next-state logic for the FSM and the col/row beat counters.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STREAM;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_STREAM: begin
                if (pop) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                if (frame_end_pop) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // The final beat is still held in the output register; wait for its handshake.
                if (hs) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output register: load on pop, and drop valid on a handshake that has no refill.
    always_comb begin
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        if (pop) begin
            tdata_d  = fifo_read_data;
            tvalid_d = 1'b1;
            tlast_d  = (col_q == COL_LAST);
            tuser_d  = (col_q == '0) && (row_q == '0);
        end else if (hs) begin
            tvalid_d = 1'b0;
        end
    end

    // State, counters and output register, all cleared immediately by reset.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q  <= S_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
            done_q   <= done_d;
        end
    end

`ifdef SEQ_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Stall counter: counts starved streaming cycles (nothing held and nothing to pop).
    always_comb begin
        stall_d = stall_q;
        if ((state_q == S_IDLE) && start) begin
            stall_d = '0;
        end else if ((state_q == S_STREAM) && fifo_empty && !tvalid_q) begin
            stall_d = sat_inc16(stall_q);
        end
    end

    // Stall counter register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
